// File: rtl/shift_defs.sv
// Shared shift-type and result-holder state encodings for the shift arbiter slice.
package shift_defs;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [3:1]  op;
        logic [32:1] data;
        logic [8:1]  num;
        logic        cin;
    } shift_req_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Two shift requesters plus one registered result channel.
interface shift_arbiter_if;
    logic        Req_Valid_0, Req_Ready_0, Carry_In_0;
    logic [3:1]  SHIFT_OP_0;
    logic [32:1] Shift_Data_0;
    logic [8:1]  Shift_Num_0;
    logic        Req_Valid_1, Req_Ready_1, Carry_In_1;
    logic [3:1]  SHIFT_OP_1;
    logic [32:1] Shift_Data_1;
    logic [8:1]  Shift_Num_1;
    logic        Res_Valid, Res_Ready, Res_Id, Shift_Carry_Out;
    logic [32:1] Shift_Out;

    modport slave (
        input  Req_Valid_0, SHIFT_OP_0, Shift_Data_0, Shift_Num_0, Carry_In_0,
        input  Req_Valid_1, SHIFT_OP_1, Shift_Data_1, Shift_Num_1, Carry_In_1,
        output Req_Ready_0, Req_Ready_1,
        output Res_Valid, Res_Id, Shift_Out, Shift_Carry_Out,
        input  Res_Ready
    );

    modport master (
        output Req_Valid_0, SHIFT_OP_0, Shift_Data_0, Shift_Num_0, Carry_In_0,
        output Req_Valid_1, SHIFT_OP_1, Shift_Data_1, Shift_Num_1, Carry_In_1,
        input  Req_Ready_0, Req_Ready_1,
        input  Res_Valid, Res_Id, Shift_Out, Shift_Carry_Out,
        output Res_Ready
    );
endinterface

// File: rtl/barrel_shifter.sv
// Combinational ARM-style shifter: LSL/LSR/ASR/ROR with immediate or register amount.
// Zero latency; no handshake.
module barrel_shifter
    import shift_defs::*;
(
    input  logic [3:1]  SHIFT_OP,
    input  logic [32:1] Shift_Data,
    input  logic [8:1]  Shift_Num,
    input  logic        Carry_In,
    output logic [32:1] Shift_Out,
    output logic        Shift_Carry_Out
);
    shift_type_t typ;
    logic        reg_mode;
    logic [7:0]  n;
    logic [4:0]  r;
    logic [31:0] d;
    logic [63:0] wide;

    assign typ      = shift_type_t'(SHIFT_OP[3:2]);
    assign reg_mode = SHIFT_OP[1];
    assign d        = Shift_Data;
    assign n        = reg_mode ? Shift_Num : {3'b000, Shift_Num[5:1]};
    assign r        = n[4:0];

    // Shifting through a 64-bit window leaves the last bit shifted out next to the result.
    always_comb begin
        Shift_Out       = Shift_Data;
        Shift_Carry_Out = Carry_In;
        wide            = '0;
        case (typ)
            SH_LSL: begin
                if (n > 8'd32) begin
                    Shift_Out       = '0;
                    Shift_Carry_Out = 1'b0;
                end else if (n != 8'd0) begin
                    wide            = {32'b0, d} << n;
                    Shift_Out       = wide[31:0];
                    Shift_Carry_Out = wide[32];
                end
            end
            SH_LSR: begin
                if (n > 8'd32) begin
                    Shift_Out       = '0;
                    Shift_Carry_Out = 1'b0;
                end else if (n != 8'd0 || !reg_mode) begin
                    wide            = {d, 32'b0} >> ((n == 8'd0) ? 8'd32 : n);
                    Shift_Out       = wide[63:32];
                    Shift_Carry_Out = wide[31];
                end
            end
            SH_ASR: begin
                if (n != 8'd0 || !reg_mode) begin
                    wide            = $signed({d, 32'b0}) >>> ((n == 8'd0 || n > 8'd32) ? 8'd32 : n);
                    Shift_Out       = wide[63:32];
                    Shift_Carry_Out = wide[31];
                end
            end
            SH_ROR: begin
                if (!reg_mode && n == 8'd0) begin
                    Shift_Out       = {Carry_In, d[31:1]};
                    Shift_Carry_Out = d[0];
                end else if (n != 8'd0) begin
                    if (r == 5'd0) begin
                        Shift_Out       = d;
                        Shift_Carry_Out = d[31];
                    end else begin
                        Shift_Out       = (d >> r) | (d << (6'd32 - {1'b0, r}));
                        Shift_Carry_Out = d[r - 5'd1];
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters, one-entry result holder.
// Latency 1 cycle from accept to Res_Valid; stalls requesters only while the result is held and not taken.
module shift_arbiter
    import shift_defs::*;
(
    input  logic           clk,
    input  logic           rst,
    shift_arbiter_if.slave bus
);
    arb_state_t  state;
    logic        last_id;
    logic        grant_id, any_vld, can_accept, accept;
    shift_req_t  req_sel;
    logic [32:1] sh_out, out_q;
    logic        sh_carry, carry_q, id_q;

    assign any_vld    = bus.Req_Valid_0 | bus.Req_Valid_1;
    assign grant_id   = (bus.Req_Valid_0 & bus.Req_Valid_1) ? ~last_id : bus.Req_Valid_1;
    assign can_accept = (state == EMPTY) | bus.Res_Ready;
    assign accept     = can_accept & any_vld & ~rst;

    assign bus.Req_Ready_0 = accept & ~grant_id;
    assign bus.Req_Ready_1 = accept &  grant_id;

    always_comb begin
        req_sel = '0;
        if (grant_id) begin
            req_sel.op   = bus.SHIFT_OP_1;
            req_sel.data = bus.Shift_Data_1;
            req_sel.num  = bus.Shift_Num_1;
            req_sel.cin  = bus.Carry_In_1;
        end else begin
            req_sel.op   = bus.SHIFT_OP_0;
            req_sel.data = bus.Shift_Data_0;
            req_sel.num  = bus.Shift_Num_0;
            req_sel.cin  = bus.Carry_In_0;
        end
    end

    barrel_shifter u_shift (
        .SHIFT_OP        (req_sel.op),
        .Shift_Data      (req_sel.data),
        .Shift_Num       (req_sel.num),
        .Carry_In        (req_sel.cin),
        .Shift_Out       (sh_out),
        .Shift_Carry_Out (sh_carry)
    );

    // last_id starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            out_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_id <= 1'b1;
        end else begin
            case (state)
                EMPTY:   if (accept) state <= FULL;
                FULL:    if (bus.Res_Ready && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (accept) begin
                out_q   <= sh_out;
                carry_q <= sh_carry;
                id_q    <= grant_id;
                last_id <= grant_id;
            end
        end
    end

    assign bus.Res_Valid       = (state == FULL);
    assign bus.Shift_Out       = out_q;
    assign bus.Shift_Carry_Out = carry_q;
    assign bus.Res_Id          = id_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed cases plus randomized traffic against a bit-serial reference model.
module tb_shift_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    shift_arbiter_if bus ();
    shift_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // expected architectural state
    logic        m_full = 1'b0;
    logic [31:0] m_out = '0;
    logic        m_c = 1'b0;
    logic        m_id = 1'b0;
    logic        m_last = 1'b1;
    logic [1:0]  m_acc = '0;

    logic [2:0]  t_op   [7] = '{3'b110, 3'b010, 3'b001, 3'b001, 3'b100, 3'b111, 3'b011};
    logic [31:0] t_data [7] = '{32'h00000003, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'h92345678, 32'h0000F00F};
    logic [7:0]  t_num  [7] = '{8'd0, 8'd0, 8'd33, 8'd32, 8'd0, 8'd32, 8'd0};
    logic        t_cin  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_out  [7] = '{32'h80000001, 32'h0, 32'h0, 32'h0,
                                32'hFFFFFFFF, 32'h92345678, 32'h0000F00F};
    logic        t_c    [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reference shifter: applies the shift one bit at a time, carry = last bit shifted out.
    task automatic ref_shift(input logic [2:0] op, input logic [31:0] data, input logic [7:0] num,
                             input logic cin, output logic [31:0] o, output logic c);
        int n;
        logic [1:0] typ;
        typ = op[2:1];
        n   = op[0] ? int'(num) : int'(num[4:0]);
        o   = data;
        c   = cin;
        if (n == 0 && !op[0]) begin
            if (typ == 2'b01 || typ == 2'b10) n = 32;
            else if (typ == 2'b11) begin
                o = {cin, data[31:1]};
                c = data[0];
                return;
            end
        end
        for (int i = 0; i < n; i++) begin
            case (typ)
                2'b00:   begin c = o[31]; o = o << 1; end
                2'b01:   begin c = o[0];  o = o >> 1; end
                2'b10:   begin c = o[0];  o = {o[31], o[31:1]}; end
                default: begin c = o[0];  o = {o[0], o[31:1]}; end
            endcase
        end
    endtask

    function automatic logic [1:0] exp_ready();
        if (rst) return 2'b00;
        if (m_full && !bus.Res_Ready) return 2'b00;
        if (bus.Req_Valid_0 && bus.Req_Valid_1) return m_last ? 2'b01 : 2'b10;
        if (bus.Req_Valid_0) return 2'b01;
        if (bus.Req_Valid_1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic advance();
        logic [1:0]  acc;
        logic [31:0] o;
        logic        c, w;
        acc = exp_ready();
        w   = acc[1];
        o   = '0;
        c   = 1'b0;
        if (acc != 2'b00) begin
            if (w) ref_shift(bus.SHIFT_OP_1, bus.Shift_Data_1, bus.Shift_Num_1, bus.Carry_In_1, o, c);
            else   ref_shift(bus.SHIFT_OP_0, bus.Shift_Data_0, bus.Shift_Num_0, bus.Carry_In_0, o, c);
        end
        @(posedge clk);
        if (rst) begin
            m_full = 1'b0; m_out = '0; m_c = 1'b0; m_id = 1'b0; m_last = 1'b1;
        end else if (acc != 2'b00) begin
            m_full = 1'b1; m_out = o; m_c = c; m_id = w; m_last = w;
        end else if (bus.Res_Ready) begin
            m_full = 1'b0;
        end
        m_acc = acc;
        #1;
    endtask

    task automatic set_req(input int k, input logic [2:0] op, input logic [31:0] data,
                           input logic [7:0] num, input logic cin);
        if (k == 0) begin
            bus.SHIFT_OP_0 = op; bus.Shift_Data_0 = data; bus.Shift_Num_0 = num; bus.Carry_In_0 = cin;
        end else begin
            bus.SHIFT_OP_1 = op; bus.Shift_Data_1 = data; bus.Shift_Num_1 = num; bus.Carry_In_1 = cin;
        end
    endtask

    task automatic rand_req(input int k);
        logic [7:0] num;
        case ($urandom_range(0, 3))
            0:       num = 8'd0;
            1:       num = 8'($urandom_range(1, 40));
            2:       num = 8'($urandom_range(31, 33));
            default: num = 8'($urandom);
        endcase
        set_req(k, 3'($urandom), $urandom, num, 1'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Req_Valid_0 = 1'b1; bus.Req_Valid_1 = 1'b1; bus.Res_Ready = 1'b1;
        rand_req(0); rand_req(1);
        advance(); advance();
        @(negedge clk);
        checks++; if (bus.Req_Ready_0 !== 1'b0) begin errs++; $display("FAIL reset_ready0: got %b want 0", bus.Req_Ready_0); end
        checks++; if (bus.Req_Ready_1 !== 1'b0) begin errs++; $display("FAIL reset_ready1: got %b want 0", bus.Req_Ready_1); end
        checks++; if (bus.Res_Valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", bus.Res_Valid); end
        checks++; if (bus.Shift_Out !== 32'h0) begin errs++; $display("FAIL reset_out: got %h want 0", bus.Shift_Out); end
        checks++; if (bus.Shift_Carry_Out !== 1'b0) begin errs++; $display("FAIL reset_carry: got %b want 0", bus.Shift_Carry_Out); end
        checks++; if (bus.Res_Id !== 1'b0) begin errs++; $display("FAIL reset_id: got %b want 0", bus.Res_Id); end
        bus.Req_Valid_0 = 1'b0; bus.Req_Valid_1 = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_asr_reg();
        set_req(0, 3'b101, 32'h80000010, 8'd4, 1'b1);
        bus.Req_Valid_0 = 1'b1; bus.Req_Valid_1 = 1'b0; bus.Res_Ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.Req_Ready_0 !== 1'b1) begin errs++; $display("FAIL asr_ready0: got %b want 1", bus.Req_Ready_0); end
        checks++; if (bus.Req_Ready_1 !== 1'b0) begin errs++; $display("FAIL asr_ready1: got %b want 0", bus.Req_Ready_1); end
        advance();
        bus.Req_Valid_0 = 1'b0;
        @(negedge clk);
        checks++; if (bus.Res_Valid !== 1'b1) begin errs++; $display("FAIL asr_valid: got %b want 1", bus.Res_Valid); end
        checks++; if (bus.Res_Id !== 1'b0) begin errs++; $display("FAIL asr_id: got %b want 0", bus.Res_Id); end
        checks++; if (bus.Shift_Out !== 32'hF8000001) begin errs++; $display("FAIL asr_out: got %h want f8000001", bus.Shift_Out); end
        checks++; if (bus.Shift_Carry_Out !== 1'b0) begin errs++; $display("FAIL asr_carry: got %b want 0", bus.Shift_Carry_Out); end
        advance();
    endtask

    task automatic test_alternate();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        rand_req(0); rand_req(1);
        bus.Req_Valid_0 = 1'b1; bus.Req_Valid_1 = 1'b1; bus.Res_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.Req_Ready_0 !== (i % 2 == 0)) begin errs++; $display("FAIL alt_ready0[%0d]: got %b want %b", i, bus.Req_Ready_0, (i % 2 == 0)); end
            checks++; if (bus.Req_Ready_1 !== (i % 2 == 1)) begin errs++; $display("FAIL alt_ready1[%0d]: got %b want %b", i, bus.Req_Ready_1, (i % 2 == 1)); end
            if (i > 0) begin
                checks++; if (bus.Res_Id !== (i % 2 == 0)) begin errs++; $display("FAIL alt_id[%0d]: got %b want %b", i, bus.Res_Id, (i % 2 == 0)); end
                checks++; if (bus.Shift_Out !== m_out) begin errs++; $display("FAIL alt_out[%0d]: got %h want %h", i, bus.Shift_Out, m_out); end
            end
            advance();
            if (m_acc[0]) rand_req(0);
            if (m_acc[1]) rand_req(1);
        end
        @(negedge clk);
        checks++; if (bus.Res_Id !== 1'b1) begin errs++; $display("FAIL alt_id_last: got %b want 1", bus.Res_Id); end
        bus.Req_Valid_0 = 1'b0; bus.Req_Valid_1 = 1'b0;
        advance();
    endtask

    task automatic test_boundaries();
        bus.Res_Ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_req(0, t_op[i], t_data[i], t_num[i], t_cin[i]);
            bus.Req_Valid_0 = 1'b1;
            advance();
            bus.Req_Valid_0 = 1'b0;
            @(negedge clk);
            checks++; if (bus.Shift_Out !== t_out[i]) begin errs++; $display("FAIL bound_out[%0d]: got %h want %h", i, bus.Shift_Out, t_out[i]); end
            checks++; if (bus.Shift_Carry_Out !== t_c[i]) begin errs++; $display("FAIL bound_carry[%0d]: got %b want %b", i, bus.Shift_Carry_Out, t_c[i]); end
        end
        advance();
    endtask

    task automatic test_backpressure();
        logic [1:0] exp;
        rand_req(0); rand_req(1);
        bus.Req_Valid_0 = 1'b1; bus.Req_Valid_1 = 1'b1; bus.Res_Ready = 1'b1;
        advance();
        if (m_acc[0]) rand_req(0);
        if (m_acc[1]) rand_req(1);
        bus.Res_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({bus.Req_Ready_1, bus.Req_Ready_0} !== 2'b00) begin errs++; $display("FAIL bp_ready[%0d]: got %b%b want 00", i, bus.Req_Ready_1, bus.Req_Ready_0); end
            checks++; if (bus.Res_Valid !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.Res_Valid); end
            checks++; if (bus.Shift_Out !== m_out || bus.Shift_Carry_Out !== m_c || bus.Res_Id !== m_id) begin
                errs++; $display("FAIL bp_hold[%0d]: got %h/%b/%b want %h/%b/%b", i, bus.Shift_Out, bus.Shift_Carry_Out, bus.Res_Id, m_out, m_c, m_id);
            end
            advance();
        end
        bus.Res_Ready = 1'b1;
        @(negedge clk);
        exp = exp_ready();
        checks++; if ({bus.Req_Ready_1, bus.Req_Ready_0} !== exp) begin errs++; $display("FAIL bp_release_ready: got %b%b want %b", bus.Req_Ready_1, bus.Req_Ready_0, exp); end
        advance();
        @(negedge clk);
        checks++; if (bus.Res_Valid !== 1'b1 || bus.Shift_Out !== m_out || bus.Res_Id !== m_id) begin
            errs++; $display("FAIL bp_reload: got %b/%h/%b want 1/%h/%b", bus.Res_Valid, bus.Shift_Out, bus.Res_Id, m_out, m_id);
        end
        bus.Req_Valid_0 = 1'b0; bus.Req_Valid_1 = 1'b0;
        advance();
    endtask

    task automatic test_reset_full();
        set_req(0, 3'b000, 32'h0000ABCD, 8'd4, 1'b0);
        bus.Req_Valid_0 = 1'b1; bus.Req_Valid_1 = 1'b0; bus.Res_Ready = 1'b1;
        advance();
        bus.Res_Ready = 1'b0;
        rand_req(0); rand_req(1);
        bus.Req_Valid_0 = 1'b1; bus.Req_Valid_1 = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.Res_Valid !== 1'b1) begin errs++; $display("FAIL rf_full_before: got %b want 1", bus.Res_Valid); end
        checks++; if ({bus.Req_Ready_1, bus.Req_Ready_0} !== 2'b00) begin errs++; $display("FAIL rf_ready_in_rst: got %b%b want 00", bus.Req_Ready_1, bus.Req_Ready_0); end
        advance();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.Res_Valid !== 1'b0 || bus.Shift_Out !== 32'h0 || bus.Shift_Carry_Out !== 1'b0 || bus.Res_Id !== 1'b0) begin
            errs++; $display("FAIL rf_cleared: got %b/%h/%b/%b want 0/0/0/0", bus.Res_Valid, bus.Shift_Out, bus.Shift_Carry_Out, bus.Res_Id);
        end
        checks++; if ({bus.Req_Ready_1, bus.Req_Ready_0} !== 2'b01) begin errs++; $display("FAIL rf_first_tie: got %b%b want 01", bus.Req_Ready_1, bus.Req_Ready_0); end
        advance();
        bus.Req_Valid_0 = 1'b0; bus.Req_Valid_1 = 1'b0;
        bus.Res_Ready = 1'b1;
        advance();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!bus.Req_Valid_0 && $urandom_range(0, 1) == 1) begin rand_req(0); bus.Req_Valid_0 = 1'b1; end
            if (!bus.Req_Valid_1 && $urandom_range(0, 1) == 1) begin rand_req(1); bus.Req_Valid_1 = 1'b1; end
            bus.Res_Ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            checks++; if ({bus.Req_Ready_1, bus.Req_Ready_0} !== exp_ready()) begin errs++; $display("FAIL rnd_ready[%0d]: got %b%b want %b", cyc, bus.Req_Ready_1, bus.Req_Ready_0, exp_ready()); end
            checks++; if (bus.Res_Valid !== m_full) begin errs++; $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, bus.Res_Valid, m_full); end
            if (m_full) begin
                checks++; if (bus.Shift_Out !== m_out || bus.Shift_Carry_Out !== m_c || bus.Res_Id !== m_id) begin
                    errs++; $display("FAIL rnd_result[%0d]: got %h/%b/%b want %h/%b/%b", cyc, bus.Shift_Out, bus.Shift_Carry_Out, bus.Res_Id, m_out, m_c, m_id);
                end
            end
            advance();
            if (m_acc[0]) begin bus.Req_Valid_0 = ($urandom_range(0, 9) < 6); rand_req(0); end
            if (m_acc[1]) begin bus.Req_Valid_1 = ($urandom_range(0, 9) < 6); rand_req(1); end
        end
    endtask

    initial begin
        bus.Req_Valid_0 = 1'b0; bus.Req_Valid_1 = 1'b0; bus.Res_Ready = 1'b0;
        set_req(0, 3'b000, 32'h0, 8'd0, 1'b0);
        set_req(1, 3'b000, 32'h0, 8'd0, 1'b0);
        test_reset();
        test_asr_reg();
        test_alternate();
        test_boundaries();
        test_backpressure();
        test_reset_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The module SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 The module SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 The module SHALL have, per requester k in {0,1} (0 = data-processing operand2, 1 = load/store scaled offset): Req_Valid_k  input  1  request present.
REQ-004 The module SHALL have, per requester: Req_Ready_k  output  1  request accepted this cycle.
REQ-005 The module SHALL have, per requester: SHIFT_OP_k  input  [3:1]  [3:2] type (00 LSL, 01 LSR, 10 ASR, 11 ROR); [1] 1 = register amount, 0 = immediate amount.
REQ-006 The module SHALL have, per requester: Shift_Data_k  input  [32:1]  operand; Shift_Num_k  input  [8:1]  amount; Carry_In_k  input  1  current C flag.
REQ-007 The module SHALL have: Res_Valid  output  1  result held; Res_Ready  input  1  consumer takes result; Res_Id  output  1  owning requester.
REQ-008 The module SHALL have: Shift_Out  output  [32:1]  result; Shift_Carry_Out  output  1  shifter carry.

Function
REQ-009 Result SHALL appear exactly 1 cycle after acceptance (registered output); throughput SHALL be 1 result per cycle under no back-pressure.
REQ-010 State machine SHALL have EMPTY (Res_Valid=0) and FULL (Res_Valid=1); can_accept = EMPTY or (FULL and Res_Ready).
REQ-011 Transitions: EMPTY -> FULL on accept; FULL -> EMPTY on Res_Ready with no accept; FULL -> FULL (reload) on Res_Ready with accept; FULL holds on Res_Ready=0.
REQ-012 Req_Ready_k SHALL be asserted only when can_accept and requester k is granted; at most one Req_Ready high per cycle.
REQ-013 Grant SHALL be round-robin: single valid requester wins; both valid -> requester other than last-accepted wins; last-accepted pointer updates only on accept.
REQ-014 While FULL and Res_Ready=0, Shift_Out, Shift_Carry_Out and Res_Id SHALL remain stable.
REQ-015 Immediate mode SHALL use amount n = Shift_Num[5:1]; register mode SHALL use n = Shift_Num[8:1].
REQ-016 LSL: n=0 -> data passthrough, carry=Carry_In; 1..32 -> data<<n, carry=Data[33-n]; >32 -> 0, carry 0.
REQ-017 LSR: imm n=0 -> treated as 32; reg n=0 -> passthrough, carry=Carry_In; 1..32 -> logical >>n, carry=Data[n]; >32 -> 0, carry 0.
REQ-018 ASR: imm n=0 -> treated as 32; reg n=0 -> passthrough, carry=Carry_In; 1..31 -> arithmetic >>n, carry=Data[n]; >=32 -> all bits Data[32], carry Data[32].
REQ-019 ROR: imm n=0 -> RRX: {Carry_In, Data[32:2]}, carry Data[1]; reg n=0 -> passthrough, carry=Carry_In; reg n!=0 with n[5:1]=0 -> passthrough, carry Data[32]; else rotate right n[5:1], carry Data[n[5:1]].
REQ-020 Shift_Carry_Out SHALL never be X; every case above SHALL drive 0 or 1.
REQ-021 Requesters SHALL hold Req_Valid and payload stable until Req_Ready; module SHALL not depend on combinational Res_Ready->Req_Valid loops beyond can_accept.

Reset
REQ-022 On rst=1 at a clock edge: state EMPTY, Res_Valid=0, Shift_Out=0, Shift_Carry_Out=0, Res_Id=0, last-accepted pointer=1 (requester 0 wins first tie).
REQ-023 Reset mid-operation SHALL discard a held result; Req_Ready_k SHALL be 0 during the reset cycle.

Structure
REQ-024 SHIFT_OP type encodings and EMPTY/FULL state encodings SHALL live in shared package shift_defs.
REQ-025 Shift computation SHALL be a combinational sub-module barrel_shifter (SHIFT_OP, Shift_Data, Shift_Num, Carry_In -> Shift_Out, Shift_Carry_Out) instantiated once after the grant mux.

Verification
REQ-026 Req0 only, ASR reg, Data=0x80000010, Num=4, Res_Ready=1 -> next cycle Res_Valid=1, Res_Id=0, Out=0xF8000001, Carry=0.
REQ-027 Both valid 4 cycles, Res_Ready=1 -> accepts alternate 0,1,0,1; Res_Id follows with 1-cycle lag.
REQ-028 ROR imm Num=0, Data=0x00000003, Carry_In=1 -> Out=0x80000001, Carry=1; LSR imm Num=0, Data=0x80000000 -> Out=0, Carry=1.
REQ-029 Res_Ready=0 for 3 cycles with both valid -> Req_Ready both 0, outputs stable; Res_Ready=1 -> held result drained and new one loaded same cycle.
REQ-030 LSL reg Num=33, Data=0xFFFFFFFF -> Out=0, Carry=0; LSL reg Num=32 -> Out=0, Carry=1.
REQ-031 rst asserted while FULL -> next cycle Res_Valid=0, outputs 0; first tie afterwards granted to requester 0.
